mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 25 ++
 rtl/mult_accum.sv | 49 ++++
 rtl/mac_sequencer.sv | 132 +++++++++++++
 tb/tb_mac_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC command sequencer: op encoding, widths and
// the command-to-result pipeline depth.
package mac_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_CLR = 2'd0,
    OP_MUL = 2'd1,
    OP_MAC = 2'd2,
    OP_MSC = 2'd3
  } op_e;

  localparam int OPND_W   = 16;
  localparam int RES_W    = 32;
  // Accept at T, result captured into the FIFO at T+PIPE_LAT.
  localparam int PIPE_LAT = 3;

  function automatic logic op_clears(input op_e op);
    return (op == OP_CLR) || (op == OP_MUL);
  endfunction

  function automatic logic op_adds(input op_e op);
    return op != OP_CLR;
  endfunction

endpackage

// File: rtl/mult_accum.sv
// Multiply-accumulate datapath: registered product, accumulator with
// clear/add/subtract, and a registered accumulator output.
module mult_accum
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_W = OPND_W,
  parameter int COEF_W = OPND_W,
  parameter int ACC_W  = RES_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              clear,
  input  logic              add,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] prod_p0;
  logic [ACC_W-1:0] acc_p1;
  logic [ACC_W-1:0] acc_p2;

  // Unsigned arithmetic wraps modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc_in,
                                                 input logic [ACC_W-1:0] prod,
                                                 input logic             do_sub);
    return do_sub ? (acc_in - prod) : (acc_in + prod);
  endfunction

  // p0: product of the operands presented this cycle
  always_ff @(posedge clk) begin
    if (en) prod_p0 <= ACC_W'(a) * ACC_W'(b);
  end

  // p1: accumulate; a clear wins over a same-cycle add
  always_ff @(posedge clk) begin
    if (clear)    acc_p1 <= '0;
    else if (add) acc_p1 <= acc_step(acc_p1, prod_p0, sub);
  end

  // p2: registered accumulator output
  always_ff @(posedge clk) begin
    acc_p2 <= acc_p1;
  end

  assign acc = acc_p2;

endmodule

// File: rtl/mac_sequencer.sv
// Command sequencer around the MAC datapath: CLR/MUL interlock, credit-based
// admission of result-producing commands, and an inline in-order result FIFO.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int RES_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_last,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  op_e              op;
  logic             interlock;
  logic             credit_ok;
  logic             accept;
  logic             clear;
  logic             push;
  logic             pop;
  logic [RES_W-1:0] acc;

  logic             vld_p0, vld_p1, vld_p2;
  logic             last_p0, last_p1, last_p2;
  logic             add_p0, sub_p0;

  logic [CNT_W-1:0] credit;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [RES_W-1:0] mem [RES_DEPTH];

  assign op = op_e'(cmd_op);

  // The datapath clears at T but adds at T+1, so a clear right after an
  // adding command would wipe that command's pending contribution.
  assign interlock = add_p0 && op_clears(op);
  assign credit_ok = !cmd_last || (credit != '0);
  assign cmd_ready = rst_n && !interlock && credit_ok;
  assign accept    = cmd_valid && cmd_ready;
  assign clear     = !rst_n || (accept && op_clears(op));

  mult_accum #(
    .DATA_W (OPND_W),
    .COEF_W (OPND_W),
    .ACC_W  (RES_W)
  ) u_mult_accum (
    .clk   (clk),
    .en    (rst_n),
    .clear (clear),
    .add   (add_p0),
    .sub   (sub_p0),
    .a     (cmd_a),
    .b     (cmd_b),
    .acc   (acc)
  );

  // p0..p2: command flags travelling alongside the datapath stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
      add_p0  <= 1'b0;
      sub_p0  <= 1'b0;
    end else begin
      vld_p0  <= accept;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      last_p0 <= accept && cmd_last;
      last_p1 <= last_p0;
      last_p2 <= last_p1;
      add_p0  <= accept && op_adds(op);
      sub_p0  <= accept && (op == OP_MSC);
    end
  end

  assign push = last_p2;
  assign pop  = res_valid && res_ready;

  // Credits reserve a FIFO slot at acceptance, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit <= CNT_W'(RES_DEPTH);
    end else begin
      case ({accept && cmd_last, pop})
        2'b10:   credit <= credit - CNT_W'(1);
        2'b01:   credit <= credit + CNT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc;
  end

  assign res_valid = rst_n && (count != '0);
  assign res_data  = res_valid ? mem[rd_ptr] : '0;
  assign busy      = rst_n && (vld_p0 || vld_p1 || vld_p2 || (count != '0));

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: directed vectors and corner sequences plus a
// randomized stream scored against a command-level accumulator model.
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  localparam int RES_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd2;
  logic        cmd_last = 1'b0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy;

  mac_sequencer #(.RES_DEPTH(RES_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_last  (cmd_last),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pops[$];
  logic [31:0] m_acc = '0;
  int          outstanding = 0;
  logic        prev_add = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_data = '0;

  typedef struct {
    logic [1:0]  op1;
    logic [15:0] a1, b1;
    logic [1:0]  op2;
    logic [15:0] a2, b2;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int idx);
    logic [31:0] v;
    v = 'x;
    if (idx < pops.size()) v = pops[idx];
    return v;
  endfunction

  // Result consumer: in-order scoreboard, stability while stalled, underflow.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", res_data, hold_data);
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow: unexpected result 0x%08h", res_data);
        end else if (res_ready) begin
          chk("result", res_data, exp_q.pop_front());
          pops.push_back(res_data);
          outstanding--;
        end
      end
      hold      = res_valid && !res_ready;
      hold_data = res_data;
    end else begin
      hold = 1'b0;
    end
  end

  // One cycle with inputs already driven: check readiness, update the model.
  task automatic step(output bit accepted);
    logic        exp_rdy;
    logic [31:0] prod;
    #1;
    exp_rdy = !(prev_add && (cmd_op == OP_CLR || cmd_op == OP_MUL))
              && !(cmd_last && outstanding >= RES_DEPTH);
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    accepted = cmd_valid && cmd_ready;
    if (accepted) begin
      prod = {16'd0, cmd_a} * {16'd0, cmd_b};
      case (cmd_op)
        OP_CLR:  m_acc = '0;
        OP_MUL:  m_acc = prod;
        OP_MAC:  m_acc = m_acc + prod;
        default: m_acc = m_acc - prod;
      endcase
      if (cmd_last) begin
        if (outstanding >= RES_DEPTH) begin
          checks++;
          errors++;
          $display("FAIL overflow: last accepted with %0d results outstanding", outstanding);
        end
        exp_q.push_back(m_acc);
        outstanding++;
      end
    end
    prev_add = accepted && (cmd_op != OP_CLR);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic last, output int stalls);
    bit acc;
    stalls    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_last  = last;
    step(acc);
    while (!acc && stalls < 40) begin
      stalls++;
      step(acc);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: op %0d not accepted after %0d cycles", op, stalls);
    end
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    cmd_op    = OP_MAC;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step(acc);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    outstanding = 0;
    prev_add    = 1'b0;
    m_acc       = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_MAC;
    cmd_last  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   st;
    bit   acc;
    int   cnt;

    tbl[0] = '{OP_CLR, 16'd0,      16'd0,      OP_MAC, 16'd3,      16'd4,      32'd12};
    tbl[1] = '{OP_MUL, 16'd2,      16'd5,      OP_MAC, 16'd3,      16'd3,      32'd19};
    tbl[2] = '{OP_MUL, 16'd10,     16'd10,     OP_MSC, 16'd1,      16'd1,      32'd99};
    tbl[3] = '{OP_CLR, 16'd0,      16'd0,      OP_MSC, 16'd1,      16'd1,      32'hFFFF_FFFF};
    tbl[4] = '{OP_MUL, 16'hFFFF,   16'hFFFF,   OP_MAC, 16'hFFFF,   16'hFFFF,   32'hFFFC_0002};
    tbl[5] = '{OP_MUL, 16'h1234,   16'h0010,   OP_MUL, 16'd7,      16'd8,      32'd56};
    tbl[6] = '{OP_CLR, 16'd0,      16'd0,      OP_CLR, 16'd9,      16'd9,      32'd0};
    tbl[7] = '{OP_MUL, 16'h8000,   16'd2,      OP_MSC, 16'h8000,   16'd2,      32'd0};

    do_reset();
    res_ready = 1'b1;

    // Accumulator starts at zero after reset
    pops.delete();
    send(OP_MAC, 16'd2, 16'd3, 1'b1, st);
    drain();
    chk("acc_after_reset", pop_at(0), 32'd6);

    // Back-to-back last commands, ordering and first-result latency
    pops.delete();
    send(OP_MUL, 16'd3, 16'd4, 1'b1, st);
    chk("res_valid_t1", 32'(res_valid), 32'd0);
    send(OP_MAC, 16'd5, 16'd6, 1'b1, st);
    chk("mac_after_mul_stall", 32'(st), 32'd0);
    chk("res_valid_t2", 32'(res_valid), 32'd0);
    cmd_valid = 1'b0;
    step(acc);
    chk("res_valid_t3", 32'(res_valid), 32'd0);
    step(acc);
    chk("res_valid_t4", 32'(res_valid), 32'd1);
    drain();
    chk("b2b_first", pop_at(0), 32'd12);
    chk("b2b_second", pop_at(1), 32'd42);

    // MUL right after MAC waits exactly one cycle
    pops.delete();
    send(OP_CLR, 16'd0, 16'd0, 1'b0, st);
    send(OP_MAC, 16'd2, 16'd3, 1'b0, st);
    chk("mac_after_clr_stall", 32'(st), 32'd0);
    send(OP_MUL, 16'd7, 16'd7, 1'b1, st);
    chk("interlock_stall", 32'(st), 32'd1);
    drain();
    chk("interlock_result", pop_at(0), 32'd49);

    // Wrap-around through subtraction
    pops.delete();
    send(OP_CLR, 16'd0, 16'd0, 1'b0, st);
    send(OP_MAC, 16'hFFFF, 16'hFFFF, 1'b0, st);
    send(OP_MSC, 16'd1, 16'd1, 1'b1, st);
    send(OP_MSC, 16'hFFFF, 16'hFFFF, 1'b1, st);
    drain();
    chk("wrap_first", pop_at(0), 32'hFFFE_0000);
    chk("wrap_second", pop_at(1), 32'hFFFF_FFFF);

    // Vector table: opening op, then a last op
    for (int i = 0; i < 8; i++) begin
      pops.delete();
      send(tbl[i].op1, tbl[i].a1, tbl[i].b1, 1'b0, st);
      send(tbl[i].op2, tbl[i].a2, tbl[i].b2, 1'b1, st);
      drain();
      chk($sformatf("vec%0d", i), pop_at(0), tbl[i].exp);
    end

    // Credit exhaustion with a stalled consumer
    pops.delete();
    res_ready = 1'b0;
    send(OP_MUL, 16'd11, 16'd1, 1'b1, st);
    send(OP_MUL, 16'd22, 16'd1, 1'b1, st);
    cmd_valid = 1'b1;
    cmd_op    = OP_MUL;
    cmd_a     = 16'd33;
    cmd_b     = 16'd1;
    cmd_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(acc);
      chk("credit_stall", 32'(acc), 32'd0);
    end
    chk("full_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    step(acc);
    chk("credit_stall_pop_cycle", 32'(acc), 32'd0);
    res_ready = 1'b0;
    step(acc);
    chk("accept_after_pop", 32'(acc), 32'd1);
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    drain();
    chk("credit_r0", pop_at(0), 32'd11);
    chk("credit_r1", pop_at(1), 32'd22);
    chk("credit_r2", pop_at(2), 32'd33);

    // Reset one cycle after a last command is accepted
    pops.delete();
    send(OP_MAC, 16'd5, 16'd5, 1'b1, st);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_res_data", res_data, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(acc);
      if (res_valid) cnt++;
    end
    chk("no_result_after_reset", 32'(cnt), 32'd0);
    send(OP_MUL, 16'd1, 16'd1, 1'b1, st);
    drain();
    chk("result_after_reset", pop_at(0), 32'd1);
    chk("single_after_reset", 32'(pops.size()), 32'd1);

    // Randomized stream scored by the model
    for (int i = 0; i < 800; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_a     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cmd_b     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cmd_last  = ($urandom_range(0, 2) == 0);
      res_ready = ($urandom_range(0, 9) < 6);
      step(acc);
    end
    cmd_last = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
